mct: RTL and testbench



---
 rtl/mct_pkg.sv | 20 ++
 rtl/mct_if.sv | 16 +
 rtl/mct.sv | 121 ++++++++++++
 tb/tb_mct.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mct_pkg.sv
// Shared definitions for the memory controller: access-size codes, FSM states
// and the byte-count helper.
package mct_pkg;

  localparam logic [1:0] CU_B = 2'd0;
  localparam logic [1:0] CU_H = 2'd1;
  localparam logic [1:0] CU_W = 2'd3;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Reserved size code 2 falls into the default and is handled as a word.
  function automatic logic [2:0] cu_len(input logic [1:0] cu);
    case (cu)
      CU_B:    return 3'd1;
      CU_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mct_if.sv
// Request/response channel between the memory stage (master) and the
// memory controller (slave).
interface mct_if;
  logic        mct_e;
  logic        mct_wr;
  logic [31:0] mct_a;
  logic [31:0] mct_n_i;
  logic [1:0]  mct_cu;
  logic [31:0] mct_n_o;
  logic        mct_ok;

  modport master (output mct_e, mct_wr, mct_a, mct_n_i, mct_cu,
                  input  mct_n_o, mct_ok);
  modport slave  (input  mct_e, mct_wr, mct_a, mct_n_i, mct_cu,
                  output mct_n_o, mct_ok);
endinterface

// File: rtl/mct.sv
// Memory controller: serialises byte/half/word loads and stores into
// LSB-first byte accesses on a byte-wide synchronous RAM port.
module mct
  import mct_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  mct_if.slave          bus,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_din,
  output logic          ram_wr,
  input  logic [7:0]    ram_dout
);

  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [2:0]    n_reg, n_next;
  logic [31:0]   d_reg, d_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic [31:0]   n_o_reg, n_o_next;
  logic          ok_reg, ok_next;
  logic [AW-1:0] ram_a_reg, ram_a_next;
  logic [7:0]    ram_din_reg, ram_din_next;
  logic          ram_wr_reg, ram_wr_next;
  logic [1:0]    wr_idx, rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      n_reg       <= '0;
      d_reg       <= '0;
      rdata_reg   <= '0;
      n_o_reg     <= '0;
      ok_reg      <= 1'b0;
      ram_a_reg   <= '0;
      ram_din_reg <= '0;
      ram_wr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      n_reg       <= n_next;
      d_reg       <= d_next;
      rdata_reg   <= rdata_next;
      n_o_reg     <= n_o_next;
      ok_reg      <= ok_next;
      ram_a_reg   <= ram_a_next;
      ram_din_reg <= ram_din_next;
      ram_wr_reg  <= ram_wr_next;
    end
  end

  // cnt_reg holds the number of edges since acceptance; in RD the capture
  // trails the issued address by two edges, so RD spans N+1 cycles.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    n_next       = n_reg;
    d_next       = d_reg;
    rdata_next   = rdata_reg;
    n_o_next     = n_o_reg;
    ok_next      = 1'b0;
    ram_a_next   = ram_a_reg;
    ram_din_next = ram_din_reg;
    ram_wr_next  = 1'b0;
    wr_idx       = cnt_reg[1:0] + 2'd1;
    rd_idx       = cnt_reg[1:0] - 2'd1;
    case (state_reg)
      IDLE: begin
        if (bus.mct_e) begin
          cnt_next   = '0;
          n_next     = cu_len(bus.mct_cu);
          d_next     = bus.mct_n_i;
          ram_a_next = bus.mct_a[AW-1:0];
          if (bus.mct_wr) begin
            ram_din_next = bus.mct_n_i[7:0];
            ram_wr_next  = 1'b1;
            state_next   = WR;
          end else begin
            rdata_next = '0;
            state_next = RD;
          end
        end
      end
      WR: begin
        if (cnt_reg == n_reg - 3'd1) begin
          ok_next    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next     = cnt_reg + 3'd1;
          ram_a_next   = ram_a_reg + AW'(1);
          ram_din_next = d_reg[{wr_idx, 3'b000} +: 8];
          ram_wr_next  = 1'b1;
        end
      end
      RD: begin
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg + 3'd1 < n_reg)
          ram_a_next = ram_a_reg + AW'(1);
        if (cnt_reg != 3'd0)
          rdata_next[{rd_idx, 3'b000} +: 8] = ram_dout;
        if (cnt_reg == n_reg) begin
          n_o_next   = rdata_next;
          ok_next    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.mct_n_o = n_o_reg;
  assign bus.mct_ok  = ok_reg;
  assign ram_a       = ram_a_reg;
  assign ram_din     = ram_din_reg;
  assign ram_wr      = ram_wr_reg;

endmodule

// File: tb/tb_mct.sv
// Directed bench for mct: byte-wide RAM model with a backdoor preload port,
// one task per scenario, hand-computed expectations.
module tb_mct;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ram_a;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a  = '0;
  logic [7:0]  pl_d  = '0;
  logic [7:0]  mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  mct_if bus ();

  mct #(.AW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .ram_a    (ram_a),
    .ram_din  (ram_din),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)       mem[pl_a] <= pl_d;
    else if (ram_wr) mem[ram_a[9:0]] <= ram_din;
    ram_dout <= mem[ram_a[9:0]];
  end

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present a request at a negedge; the following posedge is E0.
  task automatic issue(input logic wr, input logic [1:0] cu,
                       input logic [31:0] a, input logic [31:0] d);
    bus.mct_e = 1'b1; bus.mct_wr = wr; bus.mct_cu = cu;
    bus.mct_a = a;    bus.mct_n_i = d;
    @(posedge clk);
  endtask

  task automatic test_reset;
    bus.mct_e = 1'b0; bus.mct_wr = 1'b0; bus.mct_cu = 2'd0;
    bus.mct_a = '0;   bus.mct_n_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bus.mct_n_o !== 32'h0) begin errors++; $display("FAIL reset_n_o got %h want 0", bus.mct_n_o); end
    if (bus.mct_ok !== 1'b0)   begin errors++; $display("FAIL reset_ok got %b want 0", bus.mct_ok); end
    if (ram_a !== 32'h0)       begin errors++; $display("FAIL reset_ram_a got %h want 0", ram_a); end
    if (ram_din !== 8'h0)      begin errors++; $display("FAIL reset_ram_din got %h want 0", ram_din); end
    if (ram_wr !== 1'b0)       begin errors++; $display("FAIL reset_ram_wr got %b want 0", ram_wr); end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  // Generic load run: checks ok position, single pulse and returned data.
  task automatic test_load(input string name, input logic [1:0] cu, input logic [31:0] a,
                           input int exp_ok, input logic [31:0] exp_d);
    int ok_at = -1;
    int pulses = 0;
    @(negedge clk);
    issue(1'b0, cu, a, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < exp_ok - 1) begin
        checks++;
        if (ram_a !== a + k || ram_wr !== 1'b0) begin
          errors++; $display("FAIL %s_addr k=%0d got %h/%b want %h/0", name, k, ram_a, ram_wr, a + k);
        end
      end
      if (bus.mct_ok === 1'b1) begin pulses++; ok_at = k; bus.mct_e = 1'b0; end
    end
    bus.mct_e = 1'b0;
    checks += 3;
    if (ok_at != exp_ok) begin errors++; $display("FAIL %s_ok_cycle got %0d want %0d", name, ok_at, exp_ok); end
    if (pulses != 1)     begin errors++; $display("FAIL %s_ok_pulses got %0d want 1", name, pulses); end
    if (bus.mct_n_o !== exp_d) begin errors++; $display("FAIL %s_data got %h want %h", name, bus.mct_n_o, exp_d); end
    $display("txn %s a=%h data=%h ok_at=%0d", name, a, bus.mct_n_o, ok_at);
  endtask

  task automatic test_loads;
    poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
    test_load("word_load", 2'd3, 32'h100, 5, 32'h12345678);
    poke(10'h007, 8'hAB);
    test_load("byte_load", 2'd0, 32'h7, 2, 32'h000000AB);
    poke(10'h020, 8'h01); poke(10'h021, 8'h02); poke(10'h022, 8'h03); poke(10'h023, 8'h04);
    test_load("cu2_load", 2'd2, 32'h20, 5, 32'h04030201);
  endtask

  task automatic test_half_store;
    int ok_at = -1;
    poke(10'h202, 8'h00); poke(10'h203, 8'h00); poke(10'h204, 8'h55);
    @(negedge clk);
    issue(1'b1, 2'd1, 32'h202, 32'h1234BEEF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 2) begin
        checks++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h202 + k) begin
          errors++; $display("FAIL hstore_port k=%0d got %h/%b want %h/1", k, ram_a, ram_wr, 32'h202 + k);
        end
      end
      if (bus.mct_ok === 1'b1) begin ok_at = k; bus.mct_e = 1'b0; end
    end
    bus.mct_e = 1'b0;
    checks += 4;
    if (ok_at != 2)           begin errors++; $display("FAIL hstore_ok_cycle got %0d want 2", ok_at); end
    if (mem[10'h202] !== 8'hEF) begin errors++; $display("FAIL hstore_b0 got %h want ef", mem[10'h202]); end
    if (mem[10'h203] !== 8'hBE) begin errors++; $display("FAIL hstore_b1 got %h want be", mem[10'h203]); end
    if (mem[10'h204] !== 8'h55) begin errors++; $display("FAIL hstore_untouched got %h want 55", mem[10'h204]); end
    $display("txn half_store a=202 ok_at=%0d", ok_at);
  endtask

  task automatic test_reset_mid_store;
    for (int i = 0; i < 4; i++) poke(10'h010 + 10'(i), 8'h00);
    @(negedge clk);
    issue(1'b1, 2'd3, 32'h10, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (ram_wr !== 1'b0)       begin errors++; $display("FAIL rstmid_ram_wr got %b want 0", ram_wr); end
    if (ram_a !== 32'h0)       begin errors++; $display("FAIL rstmid_ram_a got %h want 0", ram_a); end
    if (ram_din !== 8'h0)      begin errors++; $display("FAIL rstmid_ram_din got %h want 0", ram_din); end
    if (bus.mct_n_o !== 32'h0) begin errors++; $display("FAIL rstmid_n_o got %h want 0", bus.mct_n_o); end
    bus.mct_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks += 2;
    if (mem[10'h010] !== 8'hEF || mem[10'h011] !== 8'hBE) begin
      errors++; $display("FAIL rstmid_written got %h %h want ef be", mem[10'h010], mem[10'h011]);
    end
    if (mem[10'h012] !== 8'h00 || mem[10'h013] !== 8'h00) begin
      errors++; $display("FAIL rstmid_unwritten got %h %h want 00 00", mem[10'h012], mem[10'h013]);
    end
    $display("txn reset_mid_store a=10");
    test_load("after_rst_load", 2'd3, 32'h10, 5, 32'h0000BEEF);
  endtask

  task automatic test_back_to_back;
    int ok_n = 0;
    int ok_at [2] = '{-1, -1};
    logic [31:0] d_at [2] = '{32'h0, 32'h0};
    poke(10'h030, 8'h11); poke(10'h031, 8'h22); poke(10'h032, 8'h33); poke(10'h033, 8'h44);
    poke(10'h040, 8'h99);
    @(negedge clk);
    issue(1'b0, 2'd3, 32'h30, 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.mct_a = 32'h40; bus.mct_cu = 2'd0; end
      if (k == 6) begin
        checks++;
        if (ram_a !== 32'h33) begin errors++; $display("FAIL b2b_hold got %h want 33", ram_a); end
      end
      if (k == 7) begin
        checks++;
        if (ram_a !== 32'h40) begin errors++; $display("FAIL b2b_second_addr got %h want 40", ram_a); end
      end
      if (bus.mct_ok === 1'b1) begin
        if (ok_n < 2) begin ok_at[ok_n] = k; d_at[ok_n] = bus.mct_n_o; end
        ok_n++;
        if (ok_n == 2) bus.mct_e = 1'b0;
      end
    end
    bus.mct_e = 1'b0;
    checks += 5;
    if (ok_n != 2)     begin errors++; $display("FAIL b2b_pulses got %0d want 2", ok_n); end
    if (ok_at[0] != 5) begin errors++; $display("FAIL b2b_ok0 got %0d want 5", ok_at[0]); end
    if (ok_at[1] != 9) begin errors++; $display("FAIL b2b_ok1 got %0d want 9", ok_at[1]); end
    if (d_at[0] !== 32'h44332211) begin errors++; $display("FAIL b2b_d0 got %h want 44332211", d_at[0]); end
    if (d_at[1] !== 32'h00000099) begin errors++; $display("FAIL b2b_d1 got %h want 00000099", d_at[1]); end
    $display("txn back_to_back ok0=%0d ok1=%0d d0=%h d1=%h", ok_at[0], ok_at[1], d_at[0], d_at[1]);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_half_store();
    test_reset_mid_store();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
